// File: rtl/clkdiv_ratio_monitor.sv
// clkdiv_ratio_monitor
// Self-check for a programmable clock divider. clk_mon_i is sampled as data
// in the clkin_i domain. Each rising-edge period is measured in clkin_i cycles.
// The monitor locks after LOCK_COUNT equal periods and then reports the ratio,
// any mismatch against expected_div_i, and loss of the divided clock.
//
// Optional feature: define CLKMON_DUTY_CHECK_EN to enable the high-time
// (duty) check. Without the macro, duty_err_o is tied low.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | monitor disabled or just enabled, nothing tracked
// ST_SEEK    | waiting for the first rising edge, no period available yet
// ST_MEASURE | collecting consecutive equal periods toward lock
// ST_LOCKED  | measured_div_o valid and stable
// ST_LOST    | no rising edge for 31 cycles (dead_o high)

module clkdiv_ratio_monitor #(
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clkin_i,
    input  logic       rstn_i,
    input  logic       clk_mon_i,
    input  logic       enable_i,
    input  logic [3:0] expected_div_i,
    output logic [3:0] measured_div_o,
    output logic       locked_o,
    output logic       mismatch_o,
    output logic       dead_o,
    output logic       duty_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK,
        ST_MEASURE,
        ST_LOCKED,
        ST_LOST
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    state_t     state_q, state_d;
    logic [2:0] sync_q;
    logic [4:0] period_cnt_q, period_cnt_d;
    logic [3:0] last_p_q, last_p_d;
    logic [3:0] match_cnt_q, match_cnt_d;
    logic [3:0] match_inc;
    logic [3:0] measured_div_q, measured_div_d;
    logic       mismatch_q, mismatch_d;
    logic       mon_rise;
    logic       timeout;
    logic       period_ok;

    // sync_q[1] is the synchronized level, and sync_q[2] is its one-cycle-old copy.
    assign mon_rise  = sync_q[1] & ~sync_q[2];
    assign timeout   = (period_cnt_q == 5'd31);
    assign period_ok = (period_cnt_q >= 5'd2) && (period_cnt_q <= 5'd15);

    // Synchronizer and edge-history flops. They keep sampling even while disabled.
    always_ff @(posedge clkin_i or negedge rstn_i) begin
        if (!rstn_i) sync_q <= 3'b000;
        else         sync_q <= {sync_q[1:0], clk_mon_i};
    end

    // Main state and measurement registers.
    always_ff @(posedge clkin_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= ST_IDLE;
            period_cnt_q   <= 5'd0;
            last_p_q       <= 4'd0;
            match_cnt_q    <= 4'd0;
            measured_div_q <= 4'd0;
            mismatch_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            period_cnt_q   <= period_cnt_d;
            last_p_q       <= last_p_d;
            match_cnt_q    <= match_cnt_d;
            measured_div_q <= measured_div_d;
            mismatch_q     <= mismatch_d;
        end
    end

    // Next-state logic: period counter, lock tracking and state transitions.
    always_comb begin
        state_d        = state_q;
        period_cnt_d   = period_cnt_q;
        last_p_d       = last_p_q;
        match_cnt_d    = match_cnt_q;
        measured_div_d = measured_div_q;
        match_inc      = match_cnt_q + 4'd1;
        if (!enable_i) begin
            state_d        = ST_IDLE;
            period_cnt_d   = 5'd0;
            last_p_d       = 4'd0;
            match_cnt_d    = 4'd0;
            measured_div_d = 4'd0;
        end else begin
            if (mon_rise)     period_cnt_d = 5'd1;
            else if (!timeout) period_cnt_d = period_cnt_q + 5'd1;

            unique case (state_q)
                ST_IDLE: state_d = ST_SEEK;
                ST_SEEK: begin
                    if (mon_rise) begin
                        state_d     = ST_MEASURE;
                        last_p_d    = 4'd0;
                        match_cnt_d = 4'd0;
                    end else if (timeout) begin
                        state_d = ST_LOST;
                    end
                end
                ST_MEASURE: begin
                    if (mon_rise) begin
                        if (period_ok) begin
                            if (period_cnt_q[3:0] == last_p_q) begin
                                match_cnt_d = match_inc;
                            end else begin
                                last_p_d    = period_cnt_q[3:0];
                                match_cnt_d = 4'd1;
                            end
                            if (match_cnt_d == LOCK_CNT) begin
                                state_d        = ST_LOCKED;
                                measured_div_d = period_cnt_q[3:0];
                            end
                        end else begin
                            match_cnt_d = 4'd0;
                        end
                    end else if (timeout) begin
                        state_d = ST_LOST;
                    end
                end
                ST_LOCKED: begin
                    if (mon_rise) begin
                        if ({1'b0, measured_div_q} != period_cnt_q) begin
                            state_d     = ST_MEASURE;
                            last_p_d    = period_ok ? period_cnt_q[3:0] : 4'd0;
                            match_cnt_d = period_ok ? 4'd1 : 4'd0;
                        end
                    end else if (timeout) begin
                        state_d = ST_LOST;
                    end
                end
                ST_LOST: begin
                    if (mon_rise) begin
                        state_d     = ST_MEASURE;
                        last_p_d    = 4'd0;
                        match_cnt_d = 4'd0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The mismatch output is one cycle behind locked and expected_div_i.
    assign mismatch_d = enable_i && (state_q == ST_LOCKED) && (measured_div_q != expected_div_i);

    assign measured_div_o = measured_div_q;
    assign locked_o       = (state_q == ST_LOCKED);
    assign dead_o         = (state_q == ST_LOST);
    assign mismatch_o     = mismatch_q;

`ifdef CLKMON_DUTY_CHECK_EN
    logic [3:0] high_cnt_q, high_cnt_d;
    logic       duty_err_q, duty_err_d;
    logic [4:0] half_up;
    logic       duty_ok;

    // high_cnt counts the edge cycle itself, so the value held at the next edge
    // equals the number of high cycles in the period just ended.
    assign half_up = ({1'b0, measured_div_q} + 5'd1) >> 1;
    assign duty_ok = (high_cnt_q == (measured_div_q >> 1)) || ({1'b0, high_cnt_q} == half_up);

    // Duty-check registers.
    always_ff @(posedge clkin_i or negedge rstn_i) begin
        if (!rstn_i) begin
            high_cnt_q <= 4'd0;
            duty_err_q <= 1'b0;
        end else begin
            high_cnt_q <= high_cnt_d;
            duty_err_q <= duty_err_d;
        end
    end

    // Update the high-time counter and the sticky error flag.
    always_comb begin
        high_cnt_d = high_cnt_q;
        duty_err_d = duty_err_q;
        if (!enable_i) begin
            high_cnt_d = 4'd0;
            duty_err_d = 1'b0;
        end else begin
            if (mon_rise)                             high_cnt_d = 4'd1;
            else if (sync_q[1] && high_cnt_q != 4'hf) high_cnt_d = high_cnt_q + 4'd1;
            if (mon_rise && state_q == ST_LOCKED && !duty_ok) duty_err_d = 1'b1;
        end
    end

    assign duty_err_o = duty_err_q;
`else
    assign duty_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_clkdiv_ratio_monitor.sv
// Testbench for clkdiv_ratio_monitor. It drives directed and random divided-clock
// waveforms and compares every output on every cycle against a period-level
// behavioural model.
module tb_clkdiv_ratio_monitor;

    localparam int LC = 4;

    logic       clkin_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       clk_mon_i = 1'b0;
    logic       enable_i = 1'b0;
    logic [3:0] expected_div_i = 4'd0;
    logic [3:0] measured_div_o;
    logic       locked_o;
    logic       mismatch_o;
    logic       dead_o;
    logic       duty_err_o;

    clkdiv_ratio_monitor #(.LOCK_COUNT(LC)) dut (
        .clkin_i       (clkin_i),
        .rstn_i        (rstn_i),
        .clk_mon_i     (clk_mon_i),
        .enable_i      (enable_i),
        .expected_div_i(expected_div_i),
        .measured_div_o(measured_div_o),
        .locked_o      (locked_o),
        .mismatch_o    (mismatch_o),
        .dead_o        (dead_o),
        .duty_err_o    (duty_err_o)
    );

    always #5 clkin_i = ~clkin_i;

    int tests = 0;
    int fails = 0;

    // Behavioural model. Lock is decided from the trailing run of equal periods.
    typedef enum {M_IDLE, M_SEEK, M_MEAS, M_LOCK, M_LOST} mmode_t;
    mmode_t m_mode;
    int     m_age, m_meas, m_high;
    bit     m_mism, m_duty;
    int     run[$];
    bit     h1, h2, h3;
    int     edges_seen = 0;

    int wave_n = 5, wave_h = 2, wave_ph = 0;

    function automatic void model_reset();
        m_mode = M_IDLE; m_age = 0; m_meas = 0; m_high = 0;
        m_mism = 0; m_duty = 0; run.delete();
        h1 = 0; h2 = 0; h3 = 0;
    endfunction

    function automatic void model_clock(input bit smp, input bit en, input int exp_div);
        bit     rise = h2 && !h3;
        int     p = (m_age > 31) ? 31 : m_age;
        mmode_t mode_old = m_mode;
        int     meas_old = m_meas;
        int     high_old = m_high;
        m_mism = en && (mode_old == M_LOCK) && (meas_old != exp_div);
        if (!en) begin
            m_mode = M_IDLE; m_age = 0; m_meas = 0; m_high = 0; m_duty = 0; run.delete();
        end else begin
            case (mode_old)
                M_IDLE: m_mode = M_SEEK;
                M_SEEK: if (rise) begin m_mode = M_MEAS; run.delete(); end
                        else if (p == 31) m_mode = M_LOST;
                M_MEAS: if (rise) begin
                            if (p >= 2 && p <= 15) begin
                                if (run.size() > 0 && run[run.size()-1] != p) run.delete();
                                run.push_back(p);
                                if (run.size() >= LC) begin m_mode = M_LOCK; m_meas = p; end
                            end else run.delete();
                        end else if (p == 31) m_mode = M_LOST;
                M_LOCK: if (rise) begin
                            if (p != meas_old) begin
                                m_mode = M_MEAS; run.delete();
                                if (p >= 2 && p <= 15) run.push_back(p);
                            end
                        end else if (p == 31) m_mode = M_LOST;
                M_LOST: if (rise) begin m_mode = M_MEAS; run.delete(); end
                default: m_mode = M_IDLE;
            endcase
`ifdef CLKMON_DUTY_CHECK_EN
            if (rise && mode_old == M_LOCK &&
                !(high_old == meas_old / 2 || high_old == (meas_old + 1) / 2)) m_duty = 1;
`endif
            m_age = rise ? 1 : ((m_age >= 31) ? 31 : m_age + 1);
            if (rise) m_high = 1;
            else if (h2 && m_high < 15) m_high = m_high + 1;
        end
        if (rise) edges_seen++;
        h3 = h2; h2 = h1; h1 = smp;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("measured_div", 8'(measured_div_o), 8'(m_meas));
        chk("locked", 8'(locked_o), 8'(m_mode == M_LOCK));
        chk("mismatch", 8'(mismatch_o), 8'(m_mism));
        chk("dead", 8'(dead_o), 8'(m_mode == M_LOST));
        chk("duty_err", 8'(duty_err_o), 8'(m_duty));
    endtask

    task automatic cyc(input bit v);
        @(negedge clkin_i);
        clk_mon_i = v;
        @(posedge clkin_i);
        if (rstn_i) model_clock(clk_mon_i, enable_i, int'(expected_div_i));
        #1 check_all();
    endtask

    task automatic wave_cyc();
        cyc(wave_ph < wave_h);
        wave_ph = (wave_ph + 1) % wave_n;
    endtask

    task automatic set_wave(input int n, input int h);
        while (wave_ph != 0) wave_cyc();
        wave_n = n; wave_h = h; wave_ph = 0;
    endtask

    task automatic run_edges(input int target, input int budget);
        int start = edges_seen;
        int n = 0;
        while ((edges_seen - start) < target && n < budget) begin
            wave_cyc();
            n++;
        end
        if ((edges_seen - start) < target) begin
            tests++;
            fails++;
            $error("FAIL edge_wait observed=%0d expected=%0d", edges_seen - start, target);
        end
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        model_reset();
        #1;
        chk("rst_measured", 8'(measured_div_o), 8'd0);
        chk("rst_locked", 8'(locked_o), 8'd0);
        chk("rst_dead", 8'(dead_o), 8'd0);
        chk("rst_mismatch", 8'(mismatch_o), 8'd0);
        chk("rst_duty", 8'(duty_err_o), 8'd0);
        @(posedge clkin_i);
        #1 check_all();
        @(negedge clkin_i);
        rstn_i = 1'b1;
        @(posedge clkin_i);
        model_clock(clk_mon_i, enable_i, int'(expected_div_i));
        #1 check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, h, per;
        model_reset();
        repeat (2) @(posedge clkin_i);
        #1 do_reset();

        // Lock at divide-by-5.
        enable_i = 1'b1; expected_div_i = 4'd5;
        wave_n = 5; wave_h = 2; wave_ph = 0;
        run_edges(4, 60);
        chk("lock_not_before_5th", 8'(locked_o), 8'd0);
        run_edges(1, 20);
        chk("lock_at_5th", 8'(locked_o), 8'd1);
        chk("meas_5", 8'(measured_div_o), 8'd5);
        wave_cyc();
        chk("no_mismatch_5", 8'(mismatch_o), 8'd0);

        // Change expected_div while locked.
        expected_div_i = 4'd7;
        wave_cyc();
        chk("mismatch_7", 8'(mismatch_o), 8'd1);
        chk("still_locked", 8'(locked_o), 8'd1);

        // Reprogram the divider to 9.
        expected_div_i = 4'd9;
        set_wave(9, 4);
        run_edges(2, 40);
        chk("unlock_on_9", 8'(locked_o), 8'd0);
        run_edges(3, 60);
        chk("relock_9", 8'(locked_o), 8'd1);
        chk("meas_9", 8'(measured_div_o), 8'd9);

        // Divide-by-1, which gives a constant clk_mon.
        set_wave(1, 1);
        repeat (40) wave_cyc();
        chk("dead_const", 8'(dead_o), 8'd1);
        chk("unlocked_const", 8'(locked_o), 8'd0);

        // Divide-by-0, which gives P=16.
        set_wave(16, 8);
        repeat (160) wave_cyc();
        chk("div0_nolock", 8'(locked_o), 8'd0);
        chk("div0_notdead", 8'(dead_o), 8'd0);

        // Divide-by-7 with a 1-cycle high time.
        enable_i = 1'b0; wave_cyc(); enable_i = 1'b1;
        expected_div_i = 4'd7;
        set_wave(7, 1);
        repeat (70) wave_cyc();
`ifdef CLKMON_DUTY_CHECK_EN
        chk("duty_set", 8'(duty_err_o), 8'd1);
        repeat (14) wave_cyc();
        chk("duty_sticky", 8'(duty_err_o), 8'd1);
`else
        chk("duty_off", 8'(duty_err_o), 8'd0);
`endif
        enable_i = 1'b0;
        wave_cyc();
        chk("duty_clr", 8'(duty_err_o), 8'd0);
        chk("disable_unlock", 8'(locked_o), 8'd0);

        // Boundary periods 2 and 15.
        enable_i = 1'b1; expected_div_i = 4'd2;
        set_wave(2, 1);
        run_edges(7, 40);
        chk("lock_2", 8'(locked_o), 8'd1);
        chk("meas_2", 8'(measured_div_o), 8'd2);
        set_wave(15, 7);
        run_edges(7, 140);
        chk("lock_15", 8'(locked_o), 8'd1);
        chk("meas_15", 8'(measured_div_o), 8'd15);

        // Reset in the middle of a measurement, then lock again.
        set_wave(6, 3);
        run_edges(3, 40);
        do_reset();
        run_edges(7, 80);
        chk("relock_after_rst", 8'(locked_o), 8'd1);
        chk("meas_6", 8'(measured_div_o), 8'd6);

        // Random segments.
        for (int s = 0; s < 24; s++) begin
            k = $urandom_range(0, 15);
            n = (k == 0) ? 16 : k;
            h = (n > 1) ? $urandom_range(1, n - 1) : 1;
            per = $urandom_range(3, 8);
            expected_div_i = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                enable_i = 1'b0;
                wave_cyc();
                enable_i = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) wave_ph = 0;
            else while (wave_ph != 0) wave_cyc();
            wave_n = n; wave_h = h;
            repeat (per * ((n == 1) ? 10 : n)) wave_cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
